// File: rtl/pipe_resource_arbiter.sv
// pipe_resource_arbiter: round-robin sharing of one multi-cycle resource between two pipelines,
// with in-flight tracking, per-pipeline flush/cancel and a watchdog abort.  Rev 1.0
`default_nettype none

module pipe_resource_arbiter #(
   parameter int DATA_W   = 32,
   parameter int MAX_WAIT = 64,
   parameter int CNT_W    = 7
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid_1,
   input  logic [DATA_W-1:0] req_data_1,
   input  logic              flush_1,
   input  logic              req_valid_2,
   input  logic [DATA_W-1:0] req_data_2,
   input  logic              flush_2,
   output logic              stall_1,
   output logic              stall_2,
   output logic              res_start,
   output logic [DATA_W-1:0] res_operand,
   input  logic              res_done,
   input  logic [DATA_W-1:0] res_result,
   output logic              resp_valid_1,
   output logic              resp_valid_2,
   output logic [DATA_W-1:0] resp_data,
   output logic              busy,
   output logic              timeout
);

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   state_t             state, state_nxt;
   logic               owner;       // 0: pipeline 1, 1: pipeline 2
   logic               last_grant;  // same encoding as owner
   logic               cancel;
   logic [CNT_W-1:0]   wait_cnt;

   logic               elig_1, elig_2;
   logic               grant_1, grant_2;
   logic               owner_flush;
   logic               deliver;
   logic               wd_fire;

   assign elig_1      = req_valid_1 & ~flush_1;
   assign elig_2      = req_valid_2 & ~flush_2;
   assign owner_flush = owner ? flush_2 : flush_1;
   // A flush arriving together with res_done still suppresses the response.
   assign deliver     = (state == BUSY) & res_done & ~cancel & ~owner_flush;

   assign stall_1 = req_valid_1 & ~grant_1;
   assign stall_2 = req_valid_2 & ~grant_2;
   assign busy    = (state == BUSY);

   always_comb begin
      state_nxt = state;
      grant_1   = 1'b0;
      grant_2   = 1'b0;
      wd_fire   = 1'b0;
      case (state)
         IDLE: begin
            grant_1 = elig_1 & (~elig_2 | last_grant);
            grant_2 = elig_2 & (~elig_1 | ~last_grant);
            if (grant_1 | grant_2) state_nxt = BUSY;
         end
         BUSY: begin
            if (res_done) begin
               state_nxt = IDLE;
            end else if (wait_cnt == CNT_W'(MAX_WAIT - 1)) begin
               state_nxt = IDLE;
               wd_fire   = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         owner        <= 1'b0;
         last_grant   <= 1'b1;
         cancel       <= 1'b0;
         wait_cnt     <= '0;
         res_start    <= 1'b0;
         res_operand  <= '0;
         resp_valid_1 <= 1'b0;
         resp_valid_2 <= 1'b0;
         resp_data    <= '0;
         timeout      <= 1'b0;
      end else begin
         state        <= state_nxt;
         res_start    <= grant_1 | grant_2;
         resp_valid_1 <= deliver & ~owner;
         resp_valid_2 <= deliver & owner;
         timeout      <= wd_fire;
         if (deliver) resp_data <= res_result;
         if (grant_1 | grant_2) begin
            owner       <= grant_2;
            last_grant  <= grant_2;
            res_operand <= grant_2 ? req_data_2 : req_data_1;
            cancel      <= 1'b0;
            wait_cnt    <= '0;
         end else if (state == BUSY) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
            if (owner_flush) cancel <= 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_pipe_resource_arbiter.sv
// tb_pipe_resource_arbiter: directed stimulus with queue-based scoreboard for pipe_resource_arbiter.
// Rev 1.0
`default_nettype none

module tb_pipe_resource_arbiter;

   localparam int DATA_W   = 32;
   localparam int MAX_WAIT = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic              req_valid_1, req_valid_2, flush_1, flush_2;
   logic [DATA_W-1:0] req_data_1, req_data_2;
   logic              stall_1, stall_2, res_start, res_done;
   logic [DATA_W-1:0] res_operand, res_result, resp_data;
   logic              resp_valid_1, resp_valid_2, busy, timeout;

   always #5 clk = ~clk;

   pipe_resource_arbiter #(.DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT), .CNT_W(7)) dut (
      .clk(clk), .reset(reset),
      .req_valid_1(req_valid_1), .req_data_1(req_data_1), .flush_1(flush_1),
      .req_valid_2(req_valid_2), .req_data_2(req_data_2), .flush_2(flush_2),
      .stall_1(stall_1), .stall_2(stall_2),
      .res_start(res_start), .res_operand(res_operand),
      .res_done(res_done), .res_result(res_result),
      .resp_valid_1(resp_valid_1), .resp_valid_2(resp_valid_2), .resp_data(resp_data),
      .busy(busy), .timeout(timeout)
   );

   // kind: 0 = res_start, 1 = resp to pipe 1, 2 = resp to pipe 2, 3 = timeout
   typedef struct {
      int                kind;
      logic [DATA_W-1:0] data;
      int                cyc;
   } ev_t;

   ev_t start_q[$];
   ev_t resp_q[$];
   int  tests = 0;
   int  fails = 0;
   int  cyc   = 0;
   int  winner;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_start(input logic [DATA_W-1:0] d);
      start_q.push_back('{0, d, cyc + 1});
   endtask

   task automatic push_resp(input int k, input logic [DATA_W-1:0] d, input int at);
      resp_q.push_back('{k, d, at});
   endtask

   // Monitor: compares every DUT output event against the scoreboard queues.
   always @(negedge clk) begin : monitor
      ev_t e;
      int  k;
      if (resp_valid_1 && resp_valid_2) check("resp_onehot", 1, 0);
      if (res_start) begin
         if (start_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_start: operand %0h at cycle %0d", res_operand, cyc);
         end else begin
            e = start_q.pop_front();
            check("start_operand", res_operand, e.data);
            check("start_cycle", cyc, e.cyc);
         end
      end
      if (resp_valid_1 || resp_valid_2 || timeout) begin
         k = timeout ? 3 : (resp_valid_2 ? 2 : 1);
         if (resp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_resp: kind %0d data %0h at cycle %0d", k, resp_data, cyc);
         end else begin
            e = resp_q.pop_front();
            check("resp_kind", k, e.kind);
            if (k != 3) check("resp_data", resp_data, e.data);
            check("resp_cycle", cyc, e.cyc);
         end
      end
   end

   initial begin
      reset = 1'b0;
      req_valid_1 = 0; req_valid_2 = 0; flush_1 = 0; flush_2 = 0;
      req_data_1 = '0; req_data_2 = '0; res_done = 0; res_result = '0;

      // reset state
      @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_res_start", res_start, 0);
      check("rst_res_operand", res_operand, 0);
      check("rst_resp_valid_1", resp_valid_1, 0);
      check("rst_resp_valid_2", resp_valid_2, 0);
      check("rst_resp_data", resp_data, 0);
      check("rst_timeout", timeout, 0);
      tick();
      reset = 1'b1;
      tick();

      // contention with a 1-cycle resource: grants alternate 1,2,1,2
      req_valid_1 = 1; req_valid_2 = 1;
      req_data_1 = 32'h101; req_data_2 = 32'h201;
      for (int i = 0; i < 4; i++) begin
         winner = (i % 2 == 0) ? 1 : 2;
         @(negedge clk);
         check("cont_stall_1_idle", stall_1, (winner == 1) ? 0 : 1);
         check("cont_stall_2_idle", stall_2, (winner == 2) ? 0 : 1);
         push_start((winner == 1) ? req_data_1 : req_data_2);
         tick();
         res_done = 1; res_result = 32'h1000 + i;
         push_resp(winner, res_result, cyc + 1);
         if (winner == 1) req_data_1 = req_data_1 + 1;
         else             req_data_2 = req_data_2 + 1;
         if (i == 3) begin req_valid_1 = 0; req_valid_2 = 0; end
         @(negedge clk);
         check("cont_busy", busy, 1);
         check("cont_stall_1_busy", stall_1, (i < 3) ? 1 : 0);
         check("cont_stall_2_busy", stall_2, (i < 3) ? 1 : 0);
         tick();
         res_done = 0;
      end

      // flushed request loses even though it would win the tie
      req_valid_1 = 1; flush_1 = 1; req_data_1 = 32'h66;
      req_valid_2 = 1; req_data_2 = 32'h55;
      @(negedge clk);
      check("flreq_stall_1", stall_1, 1);
      check("flreq_stall_2", stall_2, 0);
      push_start(32'h55);
      tick();
      req_valid_1 = 0; flush_1 = 0; req_valid_2 = 0;
      res_done = 1; res_result = 32'h77;
      push_resp(2, 32'h77, cyc + 1);
      tick();
      res_done = 0;

      // single request, resource answers 3 cycles after res_start
      req_valid_1 = 1; req_data_1 = 32'h5;
      @(negedge clk);
      check("single_stall_1", stall_1, 0);
      push_start(32'h5);
      tick();
      req_valid_1 = 0;
      tick(); tick(); tick();
      res_done = 1; res_result = 32'h19;
      push_resp(1, 32'h19, cyc + 1);
      tick();
      res_done = 0;

      // flush of the owner while in flight; waiting pipeline 1 follows
      req_valid_2 = 1; req_data_2 = 32'h22;
      @(negedge clk);
      check("flin_stall_2", stall_2, 0);
      push_start(32'h22);
      tick();
      req_valid_2 = 0; req_valid_1 = 1; req_data_1 = 32'h33;
      @(negedge clk);
      check("flin_stall_1_busy", stall_1, 1);
      tick();
      flush_2 = 1;
      tick();
      flush_2 = 0;
      tick();
      res_done = 1; res_result = 32'hAA;
      @(negedge clk);
      check("flin_busy_at_done", busy, 1);
      tick();
      res_done = 0;
      @(negedge clk);
      check("flin_busy_after", busy, 0);
      check("flin_stall_1_grant", stall_1, 0);
      push_start(32'h33);
      tick();
      req_valid_1 = 0; res_done = 1; res_result = 32'h44;
      push_resp(1, 32'h44, cyc + 1);
      tick();
      res_done = 0;

      // flush in the same cycle as res_done suppresses the response
      req_valid_1 = 1; req_data_1 = 32'h12;
      push_start(32'h12);
      tick();
      req_valid_1 = 0; res_done = 1; flush_1 = 1; res_result = 32'hEE;
      tick();
      res_done = 0; flush_1 = 0;
      @(negedge clk);
      check("flsame_busy", busy, 0);
      tick();

      // watchdog: no res_done at all
      req_valid_1 = 1; req_data_1 = 32'h99;
      push_start(32'h99);
      push_resp(3, '0, cyc + MAX_WAIT + 1);
      tick();
      req_valid_1 = 0;
      for (int i = 0; i < MAX_WAIT; i++) begin
         @(negedge clk);
         check("wd_busy", busy, 1);
         tick();
      end
      @(negedge clk);
      check("wd_busy_after", busy, 0);
      tick();
      res_done = 1; res_result = 32'hBAD;   // ignored while IDLE
      tick();
      res_done = 0;
      tick();

      // reset in the middle of BUSY
      req_valid_2 = 1; req_data_2 = 32'h34;
      @(negedge clk);
      check("rstmid_stall_2", stall_2, 0);
      tick();
      req_valid_2 = 0; reset = 1'b0;
      @(negedge clk);
      check("rstmid_busy", busy, 0);
      check("rstmid_res_start", res_start, 0);
      check("rstmid_res_operand", res_operand, 0);
      check("rstmid_resp_data", resp_data, 0);
      check("rstmid_timeout", timeout, 0);
      tick();
      reset = 1'b1; res_done = 1; res_result = 32'hDEAD;
      tick();
      res_done = 0; req_valid_1 = 1; req_data_1 = 32'h56;
      @(negedge clk);
      check("rstmid_stall_1", stall_1, 0);
      push_start(32'h56);
      tick();
      req_valid_1 = 0; res_done = 1; res_result = 32'h57;
      push_resp(1, 32'h57, cyc + 1);
      tick();
      res_done = 0;
      tick(); tick();

      check("start_q_drained", start_q.size(), 0);
      check("resp_q_drained", resp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/pipe_resource_arbiter.md
Name: pipe_resource_arbiter

Overview:
- Shares one multi-cycle shared resource (e.g. shared multiplier/ALU) between pipeline 1 and pipeline 2 inside the pipeline wrapper.
- Sits between the two pipeline stages that need the resource and the resource itself.
- Grants round-robin, stalls the losing or waiting pipeline, and tracks the single in-flight operation.
- Routes the result back to its owner, honours per-pipeline flush, and aborts hung operations with a watchdog.

Parameters:
- DATA_W, 32, width of operand and result.
- MAX_WAIT, 64, cycles in BUSY without res_done before abort (>=2).
- CNT_W, 7, watchdog counter width; must hold MAX_WAIT.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid_1  in  1  pipeline 1 requests the resource; held with data while stalled.
- req_data_1  in  DATA_W  pipeline 1 operand.
- flush_1  in  1  pipeline 1 flush.
- req_valid_2  in  1  pipeline 2 request.
- req_data_2  in  DATA_W  pipeline 2 operand.
- flush_2  in  1  pipeline 2 flush.
- stall_1  out  1  pipeline 1 request not accepted this cycle.
- stall_2  out  1  pipeline 2 request not accepted this cycle.
- res_start  out  1  one-cycle start pulse to the resource.
- res_operand  out  DATA_W  operand to the resource; stable throughout BUSY.
- res_done  in  1  resource result valid.
- res_result  in  DATA_W  resource result.
- resp_valid_1  out  1  one-cycle result pulse to pipeline 1.
- resp_valid_2  out  1  one-cycle result pulse to pipeline 2.
- resp_data  out  DATA_W  result for whichever resp_valid_x is high.
- busy  out  1  state is BUSY.
- timeout  out  1  one-cycle pulse on watchdog abort.

Behaviour:
- States: IDLE, BUSY.
- Reset (reset=0, async):
  - state=IDLE, owner=1, last_grant=2, cancel=0, wait_cnt=0.
  - All registered outputs 0: res_start, res_operand, resp_valid_x, resp_data, timeout.
  - Reset mid-BUSY abandons the operation; no response is ever issued for it.
- Eligibility: elig_x = req_valid_x & ~flush_x. A flushed request is never granted in its flush cycle.
- Grant happens in IDLE only:
  - If exactly one pipeline is eligible, grant it.
  - If both are eligible, grant the one that is not last_grant.
  - After reset, pipeline 1 wins the first tie.
- stall_x is combinational: stall_x = req_valid_x & ~(state==IDLE & grant_x). While BUSY, any req_valid_x gives stall_x=1.
- On the grant edge:
  - owner<=x, res_operand<=req_data_x, last_grant<=x, cancel<=0, wait_cnt<=0, state<=BUSY.
  - res_start=1 for exactly the first BUSY cycle.
- BUSY:
  - wait_cnt increments every cycle.
  - When res_done=1, next cycle: state=IDLE. If cancel=0, resp_valid_owner=1 and resp_data=res_result for one cycle. If cancel=1, no response.
  - res_done is accepted in the same cycle as res_start.
  - A new grant may occur in the same IDLE cycle that resp_valid is high.
  - Watchdog: if wait_cnt==MAX_WAIT-1 and res_done=0, next cycle state=IDLE and timeout=1 for one cycle; no response.
- Flush:
  - flush_x in BUSY with owner==x sets cancel=1.
  - The arbiter still waits for res_done (or timeout) before returning to IDLE, keeping the resource coherent.
  - flush of the non-owner has no effect in BUSY.
  - Flush in the same cycle as res_done with owner==x suppresses the response.
- res_done while IDLE is ignored.
- Latency: request accepted at end of cycle t; res_start in t+1; res_done in cycle t+k gives resp_valid in t+k+1.
- resp_data holds its last value when no resp_valid_x is high.
- resp_valid_1 and resp_valid_2 are never both high.

Test Plan:
- Single request: req_valid_1=1, data 0x0000_0005 at cycle 0, resource returns res_done with 0x19 three cycles after res_start -> stall_1=0 at cycle 0; res_start=1 and res_operand=5 at cycle 1; resp_valid_1=1 and resp_data=0x19 at cycle 5; resp_valid_2 stays 0.
- Contention: both valid continuously, 1-cycle resource -> grants alternate 1,2,1,2; the waiting pipeline sees stall=1 every cycle until its grant; first grant goes to pipeline 1 after reset.
- Flush in-flight: owner=2, flush_2 pulse in 2nd BUSY cycle, res_done later with 0xAA -> no resp_valid_2; return to IDLE; the next pending req_valid_1 is granted the cycle after.
- Flush on request cycle: req_valid_1=1 with flush_1=1, req_valid_2=1 -> pipeline 2 granted; stall_1=1.
- Watchdog: MAX_WAIT=4, res_done never asserts -> timeout=1 exactly 4 cycles after the grant edge; no resp_valid; busy=0 afterwards.
- Reset mid-BUSY: reset low for 1 cycle during BUSY -> all outputs 0 immediately; a later res_done produces no response; next request gets normal 1-cycle acceptance.
